// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI peripheral: receive FSM state encoding,
// SPI mode constants ({CPOL, CPHA}), register map offsets and status bit
// positions, plus a helper that builds a right-justified word mask.
// No ports (package).
// -----------------------------------------------------------------------------
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // {CPOL, CPHA}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  // Register map (byte offsets)
  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_CTRL   = 4'h8;
  localparam logic [3:0] ADDR_BRD    = 4'hC;

  // STATUS register bit indices
  localparam int STAT_TXFE = 0;
  localparam int STAT_TXFF = 1;
  localparam int STAT_RXFE = 2;
  localparam int STAT_RXFF = 3;
  localparam int STAT_RXFO = 4;
  localparam int STAT_BUSY = 5;

  // CTRL register bit indices
  localparam int CTRL_ENABLE = 15;

  // Mask covering the low (size + 1) bits; size is bits-per-word minus 1.
  function automatic logic [31:0] size_mask(input logic [4:0] size);
    return 32'hFFFF_FFFF >> (5'd31 - size);
  endfunction

endpackage

// File: rtl/spi_rx_deserializer_if.sv
// -----------------------------------------------------------------------------
// spi_rx_deserializer_if
// Push-side link between the RX deserializer and the RX FIFO.
//   rx_data  : completed word, right-justified
//   rx_valid : one-cycle push strobe
//   rx_abort : one-cycle pulse when a partial word is discarded
//   rx_ready : FIFO can accept a word (not full)
// master = deserializer, slave = FIFO.
// -----------------------------------------------------------------------------
interface spi_rx_deserializer_if;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_abort;
  logic        rx_ready;

  modport master (output rx_data, output rx_valid, output rx_abort, input rx_ready);
  modport slave  (input rx_data, input rx_valid, input rx_abort, output rx_ready);
endinterface

// File: rtl/spi_clk_edge.sv
// -----------------------------------------------------------------------------
// spi_clk_edge
// Registers the SPI clock level once and flags transitions in the cycle where
// the current and previous levels differ.
//   clk, reset : system clock, asynchronous active-low reset
//   spi_clk    : SPI clock level (clk domain)
//   mode       : {CPOL, CPHA} selecting the sample edge
//   rise, fall : one-cycle edge pulses
//   sample     : rise in modes 0/3, fall in modes 1/2
// -----------------------------------------------------------------------------
module spi_clk_edge
  import spi_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_clk,
  input  logic [1:0] mode,
  output logic       rise,
  output logic       fall,
  output logic       sample
);

  logic clk_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) clk_prev <= 1'b0;
    else        clk_prev <= spi_clk;
  end

  assign rise   =  spi_clk & ~clk_prev;
  assign fall   = ~spi_clk &  clk_prev;
  assign sample = ((mode == MODE0) || (mode == MODE3)) ? rise : fall;

endmodule

// File: rtl/spi_rx_deserializer.sv
// -----------------------------------------------------------------------------
// spi_rx_deserializer
// Receive shift engine: samples MISO on the mode-selected SPI clock edge,
// assembles MSB-first words of word_size+1 bits and pushes them to the RX
// FIFO with a one-cycle strobe. Sticky overflow when the FIFO is full.
//   clk, reset     : system clock, asynchronous active-low reset
//   enable         : low forces IDLE
//   word_size      : bits per word minus 1 (taken modulo MAX_BITS)
//   mode           : {CPOL, CPHA}
//   spi_clk_in     : SPI clock level from the baud divider
//   frame_active   : chip select asserted
//   spi_rx         : MISO pin
//   clear_overflow : W1C pulse for rx_overflow
//   rx_overflow    : sticky dropped-word flag
//   busy           : high in SHIFT or DONE
//   fifo           : rx_data / rx_valid / rx_abort / rx_ready
// Build option: SPI_RX_SYNC_EN adds a 2-flop synchronizer on spi_rx and a
// matching 2-flop delay on spi_clk_in.
// -----------------------------------------------------------------------------
module spi_rx_deserializer
  import spi_pkg::*;
#(
  parameter int MAX_BITS = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [4:0] word_size,
  input  logic [1:0] mode,
  input  logic       spi_clk_in,
  input  logic       frame_active,
  input  logic       spi_rx,
  input  logic       clear_overflow,
  output logic       rx_overflow,
  output logic       busy,
  spi_rx_deserializer_if.master fifo
);

  logic rx_s;
  logic spi_clk_s;

`ifdef SPI_RX_SYNC_EN
  // Clock gets the same delay as data so the sample still lands mid-bit.
  logic [1:0] rx_sync_reg;
  logic [1:0] clk_sync_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_sync_reg  <= 2'b00;
      clk_sync_reg <= 2'b00;
    end else begin
      rx_sync_reg  <= {rx_sync_reg[0], spi_rx};
      clk_sync_reg <= {clk_sync_reg[0], spi_clk_in};
    end
  end

  assign rx_s      = rx_sync_reg[1];
  assign spi_clk_s = clk_sync_reg[1];
`else
  assign rx_s      = spi_rx;
  assign spi_clk_s = spi_clk_in;
`endif

  state_t              state_reg, state_next;
  logic [4:0]          count_reg, count_next;
  logic [4:0]          size_reg, size_next;
  logic [1:0]          mode_reg, mode_next;
  logic [MAX_BITS-1:0] shreg_reg, shreg_next;
  logic [31:0]         data_reg, data_next;
  logic                overflow_reg, overflow_next;
  logic                valid;
  logic                abort;
  logic                sample;
  logic                unused_rise;
  logic                unused_fall;
  logic [4:0]          size_eff;
  logic [31:0]         word_masked;

  assign size_eff    = 5'(32'(word_size) % 32'(MAX_BITS));
  assign word_masked = 32'(shreg_reg) & size_mask(size_reg);

  // Edge selection uses the mode latched at frame start.
  spi_clk_edge u_edge (
    .clk     (clk),
    .reset   (reset),
    .spi_clk (spi_clk_s),
    .mode    (mode_reg),
    .rise    (unused_rise),
    .fall    (unused_fall),
    .sample  (sample)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      size_reg     <= '0;
      mode_reg     <= MODE0;
      shreg_reg    <= '0;
      data_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      size_reg     <= size_next;
      mode_reg     <= mode_next;
      shreg_reg    <= shreg_next;
      data_reg     <= data_next;
      overflow_reg <= overflow_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    size_next     = size_reg;
    mode_next     = mode_reg;
    shreg_next    = shreg_reg;
    data_next     = data_reg;
    overflow_next = overflow_reg & ~clear_overflow;
    valid         = 1'b0;
    abort         = 1'b0;

    if (!enable) begin
      state_next = IDLE;
      shreg_next = '0;
      count_next = size_eff;
    end else begin
      case (state_reg)
        IDLE: begin
          shreg_next = '0;
          count_next = size_eff;
          if (frame_active) begin
            size_next  = size_eff;
            mode_next  = mode;
            state_next = SHIFT;
          end
        end

        SHIFT: begin
          if (!frame_active) begin
            // count still at the reload value means no bit was taken yet
            abort      = (count_reg != size_reg);
            shreg_next = '0;
            count_next = size_reg;
            state_next = IDLE;
          end else if (sample) begin
            shreg_next = {shreg_reg[MAX_BITS-2:0], rx_s};
            if (count_reg == 5'd0) state_next = DONE;
            else                   count_next = count_reg - 5'd1;
          end
        end

        DONE: begin
          if (fifo.rx_ready) begin
            valid     = 1'b1;
            data_next = word_masked;
          end else begin
            overflow_next = 1'b1;   // set beats a coincident clear
          end
          shreg_next = '0;
          count_next = size_reg;
          if (!frame_active) begin
            state_next = IDLE;
          end else if (sample) begin
            // First bit of the next word arrived during DONE.
            shreg_next = {{(MAX_BITS-1){1'b0}}, rx_s};
            if (size_reg == 5'd0) begin
              state_next = DONE;
            end else begin
              count_next = size_reg - 5'd1;
              state_next = SHIFT;
            end
          end else begin
            state_next = SHIFT;
          end
        end

        default: state_next = IDLE;
      endcase
    end
  end

  // New word is visible in the strobe cycle; the register keeps it afterwards.
  assign fifo.rx_data  = valid ? word_masked : data_reg;
  assign fifo.rx_valid = valid;
  assign fifo.rx_abort = abort;
  assign rx_overflow   = overflow_reg;
  assign busy          = (state_reg != IDLE);

endmodule
